// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the digital clock timekeeping path.
//   mode_e          : FSM state encoding, also the value driven on 'mode'
//   HOUR_W/MIN_W/SEC_W : widths of the HH:MM:SS fields
//   MIN_MAX/SEC_MAX : last legal value of the minute and second fields
//   isSetMode()     : true while the user is editing a field
// ---------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // Both edit states share the frozen-time / blink / timeout behaviour.
    function automatic logic isSetMode(input mode_e m);
        return (m == MODE_SET_HOUR) || (m == MODE_SET_MIN);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for one debounced, already-synchronous button level.
// Ports:
//   clk_i   : system clock
//   rst_i   : synchronous, active-high reset (clears the history bit)
//   level_i : button level, active-high
//   pulse_o : high for exactly one cycle per press
// ---------------------------------------------------------------------------
module edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic pulse_o
);

    logic prevLevel_q;

    // History register: the level seen on the previous clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prevLevel_q <= 1'b0;
        end else begin
            prevLevel_q <= level_i;
        end
    end

    // A press is the first cycle the level is high while history is low.
    assign pulse_o = level_i & ~prevLevel_q;

endmodule

// File: rtl/time_set_controller.sv
// ---------------------------------------------------------------------------
// time_set_controller
// Keeps the HH:MM:SS counters, advances them on the 1 Hz strobe and lets the
// user set hours and minutes with two buttons. Also produces a blink flag so
// the display can flash the field under edit.
// Parameters:
//   TIMEOUT_S : ticks without a button press in an edit state before the
//               controller falls back to RUN
//   HOUR_MAX  : last hour value before wrapping to 0
// Ports:
//   clk_50MHz : system clock (the only clock)
//   rst       : synchronous, active-high reset
//   tick_1hz  : one-cycle strobe, once per second
//   btn_mode  : debounced mode button level
//   btn_inc   : debounced increment button level
//   hours     : current hours, 0..HOUR_MAX
//   minutes   : current minutes, 0..59
//   seconds   : current seconds, 0..59
//   mode      : 0=RUN, 1=SET_HOUR, 2=SET_MIN
//   blink     : display enable for the edited field
//   min_carry : one-cycle pulse when seconds wraps 59->0 in RUN
// ---------------------------------------------------------------------------
module time_set_controller
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 30,
    parameter int HOUR_MAX  = 23
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [1:0]        mode,
    output logic              blink,
    output logic              min_carry
);

    localparam int TO_W = $clog2(TIMEOUT_S + 1);

    localparam logic [HOUR_W-1:0] HOUR_LIMIT   = HOUR_W'(HOUR_MAX);
    localparam logic [MIN_W-1:0]  MIN_LIMIT    = MIN_W'(MIN_MAX);
    localparam logic [SEC_W-1:0]  SEC_LIMIT    = SEC_W'(SEC_MAX);
    localparam logic [TO_W-1:0]   TIMEOUT_LAST = TO_W'(TIMEOUT_S - 1);

    mode_e             state_q, state_d;
    logic [HOUR_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]  minutes_q, minutes_d;
    logic [SEC_W-1:0]  seconds_q, seconds_d;
    logic              blink_q, blink_d;
    logic              minCarry_q, minCarry_d;
    logic [TO_W-1:0]   timeoutCnt_q, timeoutCnt_d;

    logic modeEdge;
    logic incEdge;
    logic incApplied;
    logic timeoutExpire;

    edge_detect uModeEdge (
        .clk_i   (clk_50MHz),
        .rst_i   (rst),
        .level_i (btn_mode),
        .pulse_o (modeEdge)
    );

    edge_detect uIncEdge (
        .clk_i   (clk_50MHz),
        .rst_i   (rst),
        .level_i (btn_inc),
        .pulse_o (incEdge)
    );

    // A simultaneous mode press takes priority, so the inc press is dropped.
    assign incApplied = incEdge & ~modeEdge;

    // The tick that would bring the idle count to TIMEOUT_S expires the edit.
    // Any button edge in the same cycle restarts the count instead.
    assign timeoutExpire = isSetMode(state_q) && tick_1hz && !modeEdge &&
                           !incEdge && (timeoutCnt_q == TIMEOUT_LAST);

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q      <= MODE_RUN;
            hours_q      <= '0;
            minutes_q    <= '0;
            seconds_q    <= '0;
            blink_q      <= 1'b1;
            minCarry_q   <= 1'b0;
            timeoutCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            hours_q      <= hours_d;
            minutes_q    <= minutes_d;
            seconds_q    <= seconds_d;
            blink_q      <= blink_d;
            minCarry_q   <= minCarry_d;
            timeoutCnt_q <= timeoutCnt_d;
        end
    end

    // Next-state logic: the mode button cycles RUN->SET_HOUR->SET_MIN->RUN,
    // and an expired idle timeout drops any edit state back to RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MODE_RUN: begin
                if (modeEdge) state_d = MODE_SET_HOUR;
            end
            MODE_SET_HOUR: begin
                if (modeEdge)           state_d = MODE_SET_MIN;
                else if (timeoutExpire) state_d = MODE_RUN;
            end
            MODE_SET_MIN: begin
                if (modeEdge || timeoutExpire) state_d = MODE_RUN;
            end
            default: state_d = MODE_RUN;
        endcase
    end

    // Datapath next values: time counting in RUN, field editing in the set
    // states, plus the blink and idle-timeout bookkeeping.
    always_comb begin
        hours_d      = hours_q;
        minutes_d    = minutes_q;
        seconds_d    = seconds_q;
        blink_d      = blink_q;
        minCarry_d   = 1'b0;
        timeoutCnt_d = timeoutCnt_q;

        unique case (state_q)
            MODE_RUN: begin
                // The whole seconds->minutes->hours cascade resolves in the
                // tick cycle; a tick coinciding with a mode press still counts.
                if (tick_1hz) begin
                    if (seconds_q == SEC_LIMIT) begin
                        seconds_d  = '0;
                        minCarry_d = 1'b1;
                        if (minutes_q == MIN_LIMIT) begin
                            minutes_d = '0;
                            hours_d   = (hours_q == HOUR_LIMIT) ? '0
                                        : hours_q + HOUR_W'(1);
                        end else begin
                            minutes_d = minutes_q + MIN_W'(1);
                        end
                    end else begin
                        seconds_d = seconds_q + SEC_W'(1);
                    end
                end
            end
            MODE_SET_HOUR: begin
                if (incApplied) begin
                    hours_d = (hours_q == HOUR_LIMIT) ? '0
                              : hours_q + HOUR_W'(1);
                end
            end
            MODE_SET_MIN: begin
                if (incApplied) begin
                    minutes_d = (minutes_q == MIN_LIMIT) ? '0
                                : minutes_q + MIN_W'(1);
                end
            end
            default: ;
        endcase

        if (state_d != state_q) begin
            // Any transition restarts the idle count and shows the display.
            timeoutCnt_d = '0;
            blink_d      = 1'b1;
            // Leaving an edit state restarts the minute at second zero.
            if (state_d == MODE_RUN) seconds_d = '0;
        end else if (state_q == MODE_RUN) begin
            timeoutCnt_d = '0;
            blink_d      = 1'b1;
        end else begin
            if (modeEdge || incEdge) begin
                timeoutCnt_d = '0;
            end else if (tick_1hz) begin
                timeoutCnt_d = timeoutCnt_q + TO_W'(1);
            end

            if (incApplied) begin
                blink_d = 1'b1;
            end else if (tick_1hz) begin
                blink_d = ~blink_q;
            end
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        hours     = hours_q;
        minutes   = minutes_q;
        seconds   = seconds_q;
        mode      = state_q;
        blink     = blink_q;
        min_carry = minCarry_q;
    end

endmodule

// File: tb/tb_time_set_controller.sv
// ---------------------------------------------------------------------------
// tb_time_set_controller
// Directed, table-driven bench for time_set_controller. Each table record is
// an action (tick / mode press / inc press / both presses) repeated a number
// of times, followed by the expected time, mode, blink and the running count
// of min_carry pulses. Reset behaviour is covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_time_set_controller;

    typedef enum int {ACT_TICK, ACT_MODE, ACT_INC, ACT_BOTH} act_e;

    typedef struct {
        act_e act;
        int   rep;
        int   expHours;
        int   expMinutes;
        int   expSeconds;
        int   expMode;
        int   expBlink;
        int   expCarries;
    } vec_t;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       tick1hz = 1'b0;
    logic       btnMode = 1'b0;
    logic       btnInc = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       minCarry;

    int compareCount = 0;
    int failCount = 0;
    int carryCount = 0;

    vec_t vecs[$];

    time_set_controller #(
        .TIMEOUT_S (30),
        .HOUR_MAX  (23)
    ) dut (
        .clk_50MHz (clock),
        .rst       (rst),
        .tick_1hz  (tick1hz),
        .btn_mode  (btnMode),
        .btn_inc   (btnInc),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .mode      (mode),
        .blink     (blink),
        .min_carry (minCarry)
    );

    // 100 MHz-style bench clock; the absolute rate is irrelevant here.
    always #5 clock = ~clock;

    // Count min_carry pulses, sampled away from the active edge.
    always @(negedge clock) begin
        if (!rst && minCarry) carryCount = carryCount + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compareCount = compareCount + 1;
        if (actual != expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One action: inputs are raised on a falling edge, the tick is dropped
    // after one cycle, buttons after two, then one idle cycle.
    task automatic applyStimulus(input act_e act);
        @(negedge clock);
        tick1hz = (act == ACT_TICK);
        btnMode = (act == ACT_MODE) || (act == ACT_BOTH);
        btnInc  = (act == ACT_INC)  || (act == ACT_BOTH);
        @(negedge clock);
        tick1hz = 1'b0;
        @(negedge clock);
        btnMode = 1'b0;
        btnInc  = 1'b0;
        @(negedge clock);
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, ".hours"},     int'(hours),    0);
        checkOutput({tag, ".minutes"},   int'(minutes),  0);
        checkOutput({tag, ".seconds"},   int'(seconds),  0);
        checkOutput({tag, ".mode"},      int'(mode),     0);
        checkOutput({tag, ".blink"},     int'(blink),    1);
        checkOutput({tag, ".min_carry"}, int'(minCarry), 0);
    endtask

    initial begin
        //            act       rep  hh  mm  ss md bl carries
        vecs.push_back('{ACT_TICK, 60,  0,  1,  0, 0, 1, 1});
        vecs.push_back('{ACT_TICK,  1,  0,  1,  1, 0, 1, 1});
        vecs.push_back('{ACT_MODE,  1,  0,  1,  1, 1, 1, 1});
        vecs.push_back('{ACT_INC,  23, 23,  1,  1, 1, 1, 1});
        vecs.push_back('{ACT_MODE,  1, 23,  1,  1, 2, 1, 1});
        vecs.push_back('{ACT_INC,  58, 23, 59,  1, 2, 1, 1});
        vecs.push_back('{ACT_MODE,  1, 23, 59,  0, 0, 1, 1});
        vecs.push_back('{ACT_TICK, 58, 23, 59, 58, 0, 1, 1});
        vecs.push_back('{ACT_TICK,  1, 23, 59, 59, 0, 1, 1});
        vecs.push_back('{ACT_TICK,  1,  0,  0,  0, 0, 1, 2});
        vecs.push_back('{ACT_MODE,  1,  0,  0,  0, 1, 1, 2});
        vecs.push_back('{ACT_INC,   5,  5,  0,  0, 1, 1, 2});
        vecs.push_back('{ACT_MODE,  1,  5,  0,  0, 2, 1, 2});
        vecs.push_back('{ACT_INC,  61,  5,  1,  0, 2, 1, 2});
        vecs.push_back('{ACT_MODE,  1,  5,  1,  0, 0, 1, 2});
        vecs.push_back('{ACT_INC,   1,  5,  1,  0, 0, 1, 2});
        vecs.push_back('{ACT_MODE,  1,  5,  1,  0, 1, 1, 2});
        vecs.push_back('{ACT_TICK,  1,  5,  1,  0, 1, 0, 2});
        vecs.push_back('{ACT_TICK,  1,  5,  1,  0, 1, 1, 2});
        vecs.push_back('{ACT_TICK,  1,  5,  1,  0, 1, 0, 2});
        vecs.push_back('{ACT_INC,   1,  6,  1,  0, 1, 1, 2});
        vecs.push_back('{ACT_MODE,  1,  6,  1,  0, 2, 1, 2});
        vecs.push_back('{ACT_TICK, 29,  6,  1,  0, 2, 0, 2});
        vecs.push_back('{ACT_TICK,  1,  6,  1,  0, 0, 1, 2});
        vecs.push_back('{ACT_MODE,  1,  6,  1,  0, 1, 1, 2});
        vecs.push_back('{ACT_MODE,  1,  6,  1,  0, 2, 1, 2});
        vecs.push_back('{ACT_TICK, 29,  6,  1,  0, 2, 0, 2});
        vecs.push_back('{ACT_INC,   1,  6,  2,  0, 2, 1, 2});
        vecs.push_back('{ACT_TICK, 29,  6,  2,  0, 2, 0, 2});
        vecs.push_back('{ACT_TICK,  1,  6,  2,  0, 0, 1, 2});
        vecs.push_back('{ACT_MODE,  1,  6,  2,  0, 1, 1, 2});
        vecs.push_back('{ACT_BOTH,  1,  6,  2,  0, 2, 1, 2});

        // Power-on reset.
        repeat (3) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        checkAllReset("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].rep; r++) applyStimulus(vecs[i].act);
            checkOutput($sformatf("v%0d.hours", i),   int'(hours),   vecs[i].expHours);
            checkOutput($sformatf("v%0d.minutes", i), int'(minutes), vecs[i].expMinutes);
            checkOutput($sformatf("v%0d.seconds", i), int'(seconds), vecs[i].expSeconds);
            checkOutput($sformatf("v%0d.mode", i),    int'(mode),    vecs[i].expMode);
            checkOutput($sformatf("v%0d.blink", i),   int'(blink),   vecs[i].expBlink);
            checkOutput($sformatf("v%0d.carries", i), carryCount,    vecs[i].expCarries);
        end

        // Reset mid-SET_MIN with btn_inc held through and beyond reset.
        @(negedge clock);
        btnInc = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("held_inc.minutes", int'(minutes), 3);
        rst = 1'b1;
        repeat (2) @(negedge clock);
        checkAllReset("mid_reset");
        rst = 1'b0;
        repeat (4) @(negedge clock);
        checkAllReset("after_reset_held");
        btnInc = 1'b0;
        repeat (2) @(negedge clock);
        checkAllReset("after_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
